// File: rtl/delay_timer_sched.sv
// rtl/delay_timer_sched.sv - one delay counter shared round-robin among several sequencing FSMs
module delay_timer_sched #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic [NUM_REQ-1:0]       iReq,
   input  logic [NUM_REQ*CNT_W-1:0] iDelay,
   input  logic [NUM_REQ-1:0]       iAbort,
   output logic [NUM_REQ-1:0]       oGrant,
   output logic [NUM_REQ-1:0]       oDone,
   output logic                     oBusy,
   output logic [CNT_W-1:0]         oCntr
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SUM_W = IDX_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_owner;
   logic [IDX_W-1:0]   r_ptr;
   logic [CNT_W-1:0]   r_delay;
   logic [CNT_W-1:0]   r_cntr;
   logic [NUM_REQ-1:0] r_grant;
   logic [NUM_REQ-1:0] r_done;
   logic               r_busy;

   state_t             w_state_nxt;
   logic [IDX_W-1:0]   w_owner_nxt;
   logic [IDX_W-1:0]   w_ptr_nxt;
   logic [CNT_W-1:0]   w_delay_nxt;
   logic [CNT_W-1:0]   w_cntr_nxt;
   logic [NUM_REQ-1:0] w_grant_nxt;
   logic [NUM_REQ-1:0] w_done_nxt;
   logic               w_found;
   logic [IDX_W-1:0]   w_sel;
   logic [SUM_W-1:0]   w_idx;
   logic [CNT_W-1:0]   w_sel_delay;
   logic               w_owner_drop;

   // Round-robin search starting just after the previous owner, wrapping around.
   always_comb begin
      w_found = 1'b0;
      w_sel   = r_ptr;
      w_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_idx = {1'b0, r_ptr} + SUM_W'(i);
         if (w_idx >= SUM_W'(NUM_REQ)) begin
            w_idx = w_idx - SUM_W'(NUM_REQ);
         end
         if (!w_found && iReq[w_idx[IDX_W-1:0]]) begin
            w_found = 1'b1;
            w_sel   = w_idx[IDX_W-1:0];
         end
      end
   end

   assign w_sel_delay  = iDelay[w_sel*CNT_W +: CNT_W];
   assign w_owner_drop = iAbort[r_owner] | ~iReq[r_owner];

   // Next-state and next-output decode; abort/withdraw outranks terminal count in RUN.
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_delay_nxt = r_delay;
      w_cntr_nxt  = r_cntr;
      w_grant_nxt = r_grant;
      w_done_nxt  = '0;
      case (r_state)
         S_IDLE: begin
            w_grant_nxt = '0;
            if (w_found) begin
               w_state_nxt = S_LOAD;
               w_owner_nxt = w_sel;
               w_ptr_nxt   = w_sel;
               w_delay_nxt = w_sel_delay;
               w_grant_nxt = NUM_REQ'(1) << w_sel;
            end
         end
         S_LOAD: begin
            w_cntr_nxt  = '0;
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_owner_drop) begin
               w_state_nxt = S_IDLE;
               w_grant_nxt = '0;
            end else if (r_cntr == r_delay) begin
               w_state_nxt = S_DONE;
               w_grant_nxt = '0;
               w_done_nxt  = r_grant;
            end else begin
               w_cntr_nxt = r_cntr + CNT_W'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   // State and registered outputs; reset drops any operation in flight without oDone.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_state <= S_IDLE;
         r_owner <= '0;
         r_ptr   <= IDX_W'(NUM_REQ - 1);
         r_delay <= '0;
         r_cntr  <= '0;
         r_grant <= '0;
         r_done  <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_ptr   <= w_ptr_nxt;
         r_delay <= w_delay_nxt;
         r_cntr  <= w_cntr_nxt;
         r_grant <= w_grant_nxt;
         r_done  <= w_done_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   assign oGrant = r_grant;
   assign oDone  = r_done;
   assign oBusy  = r_busy;
   assign oCntr  = r_cntr;

endmodule
